videoram_mp: RTL and testbench

//  Multi-read-port synchronous video RAM: 1 write port with byte-lane enables, NRD independent read ports.

---
 rtl/vram_pkg.sv | 18 +
 rtl/videoram_bank.sv | 58 +++++
 rtl/videoram_mp.sv | 162 ++++++++++++++++
 tb/tb_videoram_mp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types, default widths and helpers for the multi-port video RAM.
package vram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam int DWIDTH_DEF = 16;
   localparam int AWIDTH_DEF = 8;
   localparam int LANEW_DEF  = 8;
   localparam int NRD_DEF    = 2;

   function automatic int nlane(input int dwidth, input int lanew);
      return dwidth / lanew;
   endfunction

endpackage

// File: rtl/videoram_bank.sv
// One 1W1R synchronous RAM bank with byte-lane write enables and read-first collisions.
module videoram_bank
   import vram_pkg::*;
#(
   parameter int DWIDTH    = DWIDTH_DEF,
   parameter int AWIDTH    = AWIDTH_DEF,
   parameter int LANEW     = LANEW_DEF,
   parameter     INIT_FILE = ""
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             we,
   input  logic [AWIDTH-1:0]                waddr,
   input  logic [DWIDTH-1:0]                wdata,
   input  logic [nlane(DWIDTH, LANEW)-1:0]  wbe,
   input  logic                             re,
   input  logic [AWIDTH-1:0]                raddr,
   output logic [DWIDTH-1:0]                rdata
);

   localparam int NLANE = nlane(DWIDTH, LANEW);
   localparam int DEPTH = 2 ** AWIDTH;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [DWIDTH-1:0] rdata_d;
   logic [DWIDTH-1:0] rdata_q;

   // Lane-masked write: disabled lanes keep their previous contents.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NLANE; i++) begin
            if (wbe[i]) begin
               mem[waddr][i*LANEW +: LANEW] <= wdata[i*LANEW +: LANEW];
            end
         end
      end
   end

   // Read path samples the pre-edge array so a same-edge write is not visible (read-first).
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   // Read data register; holds its value when no read is issued.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/videoram_mp.sv
// Multi-read-port video RAM: one lane-masked write stream replicated into one bank per
// read port, a hardware clear sequencer, and per-port valid / optional output stage.
module videoram_mp
   import vram_pkg::*;
#(
   parameter int                DWIDTH    = DWIDTH_DEF,
   parameter int                AWIDTH    = AWIDTH_DEF,
   parameter int                LANEW     = LANEW_DEF,
   parameter int                NRD       = NRD_DEF,
   parameter int                OREG      = 0,
   parameter                    INIT_FILE = "vram.txt",
   parameter logic [DWIDTH-1:0] CLEAR_VAL = '0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             we,
   input  logic [AWIDTH-1:0]                waddr,
   input  logic [DWIDTH-1:0]                wdata,
   input  logic [nlane(DWIDTH, LANEW)-1:0]  wbe,
   input  logic [NRD-1:0]                   re,
   input  logic [NRD*AWIDTH-1:0]            raddr,
   output logic [NRD*DWIDTH-1:0]            rdata,
   output logic [NRD-1:0]                   rvalid,
   input  logic                             clr,
   output logic                             busy
);

   localparam int                NLANE    = nlane(DWIDTH, LANEW);
   localparam logic [AWIDTH-1:0] CNT_LAST = '1;

   if ((DWIDTH % LANEW) != 0) begin : g_lane_check
      $error("videoram_mp: DWIDTH must be a multiple of LANEW");
   end
   if (NRD < 1) begin : g_nrd_check
      $error("videoram_mp: NRD must be at least 1");
   end

   clr_state_t          state_d, state_q;
   logic [AWIDTH-1:0]   cnt_d, cnt_q;
   logic                bank_we;
   logic [AWIDTH-1:0]   bank_waddr;
   logic [DWIDTH-1:0]   bank_wdata;
   logic [NLANE-1:0]    bank_wbe;
   logic [NRD*DWIDTH-1:0] bank_rdata;
   logic [NRD-1:0]      rvalid1_d, rvalid1_q;

   // Clear sequencer next state plus write mux: the sequencer owns the write port while clearing,
   // clr beats a same-edge external write, and nothing is written while reset is asserted.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bank_we    = 1'b0;
      bank_waddr = waddr;
      bank_wdata = wdata;
      bank_wbe   = wbe;
      unique case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (we) begin
               bank_we = 1'b1;
            end
         end
         CLEAR: begin
            bank_we    = 1'b1;
            bank_waddr = cnt_q;
            bank_wdata = CLEAR_VAL;
            bank_wbe   = '1;
            cnt_d      = cnt_q + AWIDTH'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!rst_n) begin
         bank_we = 1'b0;
      end
   end

   // Clear sequencer state and address counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q == CLEAR);

   // One bank per read port, all fed the identical write stream.
   for (genvar p = 0; p < NRD; p++) begin : g_bank
      videoram_bank #(
         .DWIDTH    (DWIDTH),
         .AWIDTH    (AWIDTH),
         .LANEW     (LANEW),
         .INIT_FILE (INIT_FILE)
      ) u_bank (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (bank_we),
         .waddr (bank_waddr),
         .wdata (bank_wdata),
         .wbe   (bank_wbe),
         .re    (re[p]),
         .raddr (raddr[p*AWIDTH +: AWIDTH]),
         .rdata (bank_rdata[p*DWIDTH +: DWIDTH])
      );
   end

   // First-stage valid tracks the read enables one clock behind.
   always_comb begin
      rvalid1_d = re;
   end

   // First-stage valid register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid1_q <= '0;
      end else begin
         rvalid1_q <= rvalid1_d;
      end
   end

   if (OREG != 0) begin : g_oreg
      logic [NRD-1:0]        rvalid2_d, rvalid2_q;
      logic [NRD*DWIDTH-1:0] rdata2_d, rdata2_q;

      // Output stage captures only valid bank data so rdata holds between reads.
      always_comb begin
         rvalid2_d = rvalid1_q;
         rdata2_d  = rdata2_q;
         for (int p = 0; p < NRD; p++) begin
            if (rvalid1_q[p]) begin
               rdata2_d[p*DWIDTH +: DWIDTH] = bank_rdata[p*DWIDTH +: DWIDTH];
            end
         end
      end

      // Output stage registers.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            rvalid2_q <= '0;
            rdata2_q  <= '0;
         end else begin
            rvalid2_q <= rvalid2_d;
            rdata2_q  <= rdata2_d;
         end
      end

      assign rdata  = rdata2_q;
      assign rvalid = rvalid2_q;
   end else begin : g_noreg
      assign rdata  = bank_rdata;
      assign rvalid = rvalid1_q;
   end

endmodule

// File: tb/tb_videoram_mp.sv
// Self-checking bench: two instances (latency 1 and latency 2) share one stimulus stream and
// are compared every cycle against a transaction-level memory model, plus directed sequences.
module tb_videoram_mp;

   localparam logic [15:0] CV = 16'h0F5A;

   logic        clk = 1'b0;
   logic        rst_n, we, clr;
   logic [7:0]  waddr;
   logic [15:0] wdata;
   logic [1:0]  wbe, re;
   logic [15:0] raddr;
   logic [31:0] rdata0, rdata1;
   logic [1:0]  rvalid0, rvalid1;
   logic        busy0, busy1;

   always #5 clk = ~clk;

   videoram_mp #(
      .DWIDTH(16), .AWIDTH(8), .LANEW(8), .NRD(2), .OREG(0), .INIT_FILE(""), .CLEAR_VAL(CV)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .clr(clr), .busy(busy0)
   );

   videoram_mp #(
      .DWIDTH(16), .AWIDTH(8), .LANEW(8), .NRD(2), .OREG(1), .INIT_FILE(""), .CLEAR_VAL(CV)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .clr(clr), .busy(busy1)
   );

   typedef struct {
      logic        we;
      logic [7:0]  waddr;
      logic [15:0] wdata;
      logic [1:0]  wbe;
      logic        re;
      logic [7:0]  raddr;
      logic        exp_v;
      logic [15:0] exp_d;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain array memory, clear-in-progress flag with next address,
   // and per-port results as seen one and two clocks after the read.
   logic [15:0] mem_m [256];
   bit          busy_m;
   int          cnt_m;
   bit          s1v [2];
   bit          s2v [2];
   logic [15:0] s1d [2];
   logic [15:0] s2d [2];
   logic [15:0] snap [256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic modelEdge();
      if (!rst_n) begin
         busy_m = 0;
         cnt_m  = 0;
         for (int p = 0; p < 2; p++) begin
            s1v[p] = 0; s2v[p] = 0; s1d[p] = '0; s2d[p] = '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            s2d[p] = s1v[p] ? s1d[p] : s2d[p];
            s2v[p] = s1v[p];
            s1v[p] = re[p];
            if (re[p]) s1d[p] = mem_m[raddr[p*8 +: 8]];
         end
         if (busy_m) begin
            mem_m[cnt_m] = CV;
            cnt_m++;
            if (cnt_m == 256) begin
               busy_m = 0;
               cnt_m  = 0;
            end
         end else if (clr) begin
            busy_m = 1;
            cnt_m  = 0;
         end else if (we) begin
            for (int l = 0; l < 2; l++) begin
               if (wbe[l]) mem_m[waddr][l*8 +: 8] = wdata[l*8 +: 8];
            end
         end
      end
   endtask

   task automatic checkOutput();
      for (int p = 0; p < 2; p++) begin
         check($sformatf("dut0 rvalid[%0d]", p), 32'(rvalid0[p]), 32'(s1v[p]));
         check($sformatf("dut0 rdata[%0d]", p), 32'(rdata0[p*16 +: 16]), 32'(s1d[p]));
         check($sformatf("dut1 rvalid[%0d]", p), 32'(rvalid1[p]), 32'(s2v[p]));
         check($sformatf("dut1 rdata[%0d]", p), 32'(rdata1[p*16 +: 16]), 32'(s2d[p]));
      end
      check("dut0 busy", 32'(busy0), 32'(busy_m));
      check("dut1 busy", 32'(busy1), 32'(busy_m));
   endtask

   task automatic applyStimulus(input logic i_we, input logic [7:0] i_waddr,
                                input logic [15:0] i_wdata, input logic [1:0] i_wbe,
                                input logic [1:0] i_re, input logic [7:0] i_a0,
                                input logic [7:0] i_a1, input logic i_clr);
      we    = i_we;
      waddr = i_waddr;
      wdata = i_wdata;
      wbe   = i_wbe;
      re    = i_re;
      raddr = {i_a1, i_a0};
      clr   = i_clr;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 8'h00, 16'h0000, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
   endtask

   vec_t vecs [12];

   initial begin
      int          busy_cnt, c0, c1;
      logic [15:0] tmp, e0, e1;

      vecs[0]  = '{1'b1, 8'h10, 16'hA5C3, 2'b11, 1'b0, 8'h00, 1'b0, CV};
      vecs[1]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h10, 1'b1, 16'hA5C3};
      vecs[2]  = '{1'b1, 8'h20, 16'hFFFF, 2'b11, 1'b0, 8'h00, 1'b0, 16'hA5C3};
      vecs[3]  = '{1'b1, 8'h20, 16'h1234, 2'b01, 1'b0, 8'h00, 1'b0, 16'hA5C3};
      vecs[4]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h20, 1'b1, 16'hFF34};
      vecs[5]  = '{1'b1, 8'h30, 16'h0000, 2'b11, 1'b0, 8'h00, 1'b0, 16'hFF34};
      vecs[6]  = '{1'b1, 8'h30, 16'hBEEF, 2'b11, 1'b1, 8'h30, 1'b1, 16'h0000};
      vecs[7]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h30, 1'b1, 16'hBEEF};
      vecs[8]  = '{1'b1, 8'h20, 16'h5555, 2'b00, 1'b1, 8'h20, 1'b1, 16'hFF34};
      vecs[9]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h20, 1'b1, 16'hFF34};
      vecs[10] = '{1'b1, 8'h20, 16'h00AA, 2'b10, 1'b1, 8'h20, 1'b1, 16'hFF34};
      vecs[11] = '{1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, 8'h20, 1'b1, 16'h0034};

      for (int a = 0; a < 256; a++) mem_m[a] = '0;

      // Reset
      rst_n = 1'b0;
      idle();
      idle();
      check("reset rvalid dut0", 32'(rvalid0), 32'd0);
      check("reset rvalid dut1", 32'(rvalid1), 32'd0);
      check("reset rdata dut0", rdata0, 32'd0);
      check("reset rdata dut1", rdata1, 32'd0);
      check("reset busy", 32'({busy1, busy0}), 32'd0);
      rst_n = 1'b1;

      // Full clear: mid-clear write and a second clr must both be ignored
      applyStimulus(1'b0, 8'h00, 16'h0000, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
      busy_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         if (!busy0) break;
         busy_cnt++;
         if (busy_cnt == 100)
            applyStimulus(1'b1, 8'h05, 16'h1111, 2'b11, 2'b00, 8'h00, 8'h00, 1'b0);
         else if (busy_cnt == 150)
            applyStimulus(1'b0, 8'h00, 16'h0000, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
         else
            idle();
      end
      check("clear busy length", 32'(busy_cnt), 32'd256);
      for (int a = 0; a < 256; a++) begin
         applyStimulus(1'b0, 8'h00, 16'h0000, 2'b00, 2'b11, 8'(a), 8'(255 - a), 1'b0);
         check($sformatf("clear readback %0d", a), 32'(rdata0[15:0]), 32'(CV));
      end

      // Directed vector table on port 0 of the latency-1 instance
      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].wbe,
                       {1'b0, vecs[v].re}, vecs[v].raddr, 8'h00, 1'b0);
         check($sformatf("vec%0d rvalid", v), 32'(rvalid0[0]), 32'(vecs[v].exp_v));
         check($sformatf("vec%0d rdata", v), 32'(rdata0[15:0]), 32'(vecs[v].exp_d));
      end

      // Back-to-back dual-port streams
      for (int i = 0; i < 8; i++) begin
         tmp = 16'h1000 + 16'(i) * 16'h0111;
         applyStimulus(1'b1, 8'(i), tmp, 2'b11, 2'b00, 8'h00, 8'h00, 1'b0);
      end
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) applyStimulus(1'b0, 8'h00, 16'h0000, 2'b00, 2'b11, 8'(i), 8'(7 - i), 1'b0);
         else       idle();
         if (rvalid0 == 2'b11) c0++;
         if (rvalid1 == 2'b11) c1++;
         if (i < 8) begin
            e0 = 16'h1000 + 16'(i) * 16'h0111;
            e1 = 16'h1000 + 16'(7 - i) * 16'h0111;
            check($sformatf("stream p0 %0d", i), 32'(rdata0[15:0]), 32'(e0));
            check($sformatf("stream p1 %0d", i), 32'(rdata0[31:16]), 32'(e1));
         end
         if (i == 0) check("oreg first latency", 32'(rvalid1), 32'd0);
         if (i == 8) check("oreg last valid", 32'({rvalid1, rvalid0}), 32'b1100);
      end
      check("stream valid count dut0", 32'(c0), 32'd8);
      check("stream valid count dut1", 32'(c1), 32'd8);

      // Randomized traffic on a small address window to force collisions
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom), 2'($urandom),
                       2'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b0);
      end

      // Reset in the middle of a clear
      for (int a = 0; a < 256; a++) begin
         snap[a] = 16'($urandom);
         applyStimulus(1'b1, 8'(a), snap[a], 2'b11, 2'b00, 8'h00, 8'h00, 1'b0);
      end
      applyStimulus(1'b1, 8'd200, 16'h2222, 2'b11, 2'b00, 8'h00, 8'h00, 1'b1);
      for (int i = 0; i < 100; i++) idle();
      rst_n = 1'b0;
      idle();
      check("abort busy", 32'({busy1, busy0}), 32'd0);
      check("abort rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      rst_n = 1'b1;
      for (int a = 0; a < 256; a++) begin
         applyStimulus(1'b0, 8'h00, 16'h0000, 2'b00, 2'b11, 8'(a), 8'(a), 1'b0);
         e0 = (a < 100) ? CV : snap[a];
         check($sformatf("abort readback %0d", a), 32'(rdata0[15:0]), 32'(e0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
